// File: rtl/hazard_unit_mc_pkg.sv
// Shared types for the RV32IM hazard unit.
// Contents:
//   - fwd_sel_e:   operand forwarding mux select encoding.
//   - div_state_e: divider stall FSM states.
//   - REG_AW_DEF:  default register-index width.
//   - fwd_sel():   forwarding select from the M and W hit flags. M wins over W.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_e;

    // The M stage holds the younger result, so it takes priority over W.
    function automatic fwd_sel_e fwd_sel(input logic hit_m, input logic hit_w);
        if (hit_m)      return FWD_M;
        else if (hit_w) return FWD_W;
        else            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline <-> hazard unit signal bundle.
// Modport roles:
//   master: the pipeline datapath. It drives the register indices and control
//           flags, and receives the forwarding, stall, flush and divider controls.
//   slave:  the hazard unit.
// Parameters:
//   REG_AW: register-index width.
//   CNT_W:  width of the divide-stall performance counter.
interface hazard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) ();
    logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic              regwriteM, regwriteW;
    logic              ResultSrcE0, PCSrcE, RtypedivE, DIV_validE;
    logic [1:0]        forwardaE, forwardbE;
    logic              stallF, stallD, stallE;
    logic              flushD, flushE, flushM;
    logic              div_startE, div_busy;
    logic [CNT_W-1:0]  div_stall_cnt;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output regwriteM, regwriteW, ResultSrcE0, PCSrcE, RtypedivE, DIV_validE,
        input  forwardaE, forwardbE, stallF, stallD, stallE,
        input  flushD, flushE, flushM, div_startE, div_busy, div_stall_cnt
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  regwriteM, regwriteW, ResultSrcE0, PCSrcE, RtypedivE, DIV_validE,
        output forwardaE, forwardbE, stallF, stallD, stallE,
        output flushD, flushE, flushM, div_startE, div_busy, div_stall_cnt
    );
endinterface

// File: rtl/hazard_unit_mc_div_stall_fsm.sv
// Multi-cycle divider stall controller.
// A valid divide arriving in E while the FSM is IDLE pulses div_start for one
// cycle. When DIV_LAT > 1, it also holds div_stall for DIV_LAT-1 cycles: the
// start cycle plus DIV_LAT-2 BUSY cycles. The final BUSY cycle releases the stall
// so that the divide moves to M. The stall_cnt output saturates at all-ones.
// Ports:
//   clk, rst_n: clock and asynchronous active-low reset.
//   div_req:    a valid DIV/REM instruction is in E.
//   div_start:  one-cycle launch pulse.
//   div_stall:  freeze F/D/E and bubble M.
//   busy:       the FSM is in BUSY.
//   stall_cnt:  saturating count of stall cycles.
module div_stall_fsm
    import hazard_pkg::*;
#(
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_req,
    output logic             div_start,
    output logic             div_stall,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int            CW   = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
    localparam logic [CW-1:0] LOAD = CW'((DIV_LAT >= 2) ? DIV_LAT - 2 : 0);

    div_state_e    state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_start = 1'b0;
        div_stall = 1'b0;
        case (state)
            IDLE: if (div_req) begin
                div_start = 1'b1;
                // A single-cycle divider completes in place and needs no stall.
                if (DIV_LAT > 1) begin
                    div_stall = 1'b1;
                    cnt_n     = LOAD;
                    state_n   = BUSY;
                end
            end
            BUSY: if (cnt != '0) begin
                div_stall = 1'b1;
                cnt_n     = cnt - CW'(1);
            end else begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Reset is asynchronous, so the controls must drop with it and not
        // wait for the next clock edge.
        if (!rst_n) begin
            div_start = 1'b0;
            div_stall = 1'b0;
        end
    end

    assign busy = (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (div_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RV32IM pipeline.
// Responsibilities:
//   - M/W -> E operand forwarding (combinational).
//   - Load-use stall.
//   - Branch flush.
//   - Multi-cycle divider stall. While a divide is held in E, F/D/E are frozen
//     and M receives bubbles. While the divider stalls, flushes are masked so
//     that the held divide is never killed.
// Ports:
//   clk, rst_n: clock and asynchronous active-low reset.
//   hz:         hazard_if slave. It carries the pipeline indices and flags in,
//               and the forward, stall, flush and divider controls out.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    hazard_if.slave hz
);
    logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic              hit_ma, hit_wa, hit_mb, hit_wb;
    logic              lwstall, div_stall;

    assign rs1D = hz.rs1D;
    assign rs2D = hz.rs2D;
    assign rs1E = hz.rs1E;
    assign rs2E = hz.rs2E;
    assign rdE  = hz.rdE;
    assign rdM  = hz.rdM;
    assign rdW  = hz.rdW;

    // x0 is hardwired to zero, so it is never forwarded.
    assign hit_ma = (rs1E != '0) && (rs1E == rdM) && hz.regwriteM;
    assign hit_wa = (rs1E != '0) && (rs1E == rdW) && hz.regwriteW;
    assign hit_mb = (rs2E != '0) && (rs2E == rdM) && hz.regwriteM;
    assign hit_wb = (rs2E != '0) && (rs2E == rdW) && hz.regwriteW;

    assign hz.forwardaE = fwd_sel(hit_ma, hit_wa);
    assign hz.forwardbE = fwd_sel(hit_mb, hit_wb);

    // A load into x0 produces no real dependency.
    assign lwstall = rst_n && hz.ResultSrcE0 && (rdE != '0) &&
                     ((rdE == rs1D) || (rdE == rs2D));

    div_stall_fsm #(
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_req   (hz.RtypedivE && hz.DIV_validE),
        .div_start (hz.div_startE),
        .div_stall (div_stall),
        .busy      (hz.div_busy),
        .stall_cnt (hz.div_stall_cnt)
    );

    assign hz.stallE = div_stall;
    assign hz.stallD = lwstall || div_stall;
    assign hz.stallF = lwstall || div_stall;
    assign hz.flushM = div_stall;
    assign hz.flushE = rst_n && (lwstall || hz.PCSrcE) && !div_stall;
    assign hz.flushD = rst_n && hz.PCSrcE && !div_stall;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc. All four DUT configurations receive the same
// stimulus:
//   g[0]: DIV_LAT=8, CNT_W=16
//   g[1]: DIV_LAT=4, CNT_W=16
//   g[2]: DIV_LAT=1, CNT_W=16
//   g[3]: DIV_LAT=4, CNT_W=3
// The reference model tracks each divide by its start cycle. Stall, busy and
// count are derived from cycle arithmetic.
module tb_hazard_unit_mc;

    logic       clk, rst_n;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       regwriteM, regwriteW, ResultSrcE0, PCSrcE, RtypedivE, DIV_validE;

    logic [3:0][1:0]  fa_a, fb_a;
    logic [3:0][7:0]  ctl_a;   // {stallF,stallD,stallE,flushD,flushE,flushM,div_startE,div_busy}
    logic [3:0][15:0] cnt_a;

    int tests = 0;
    int fails = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 8 : (g == 2) ? 1 : 4;
        localparam int CW  = (g == 3) ? 3 : 16;

        hazard_if #(.REG_AW(5), .CNT_W(CW)) hif ();

        assign hif.rs1D        = rs1D;
        assign hif.rs2D        = rs2D;
        assign hif.rs1E        = rs1E;
        assign hif.rs2E        = rs2E;
        assign hif.rdE         = rdE;
        assign hif.rdM         = rdM;
        assign hif.rdW         = rdW;
        assign hif.regwriteM   = regwriteM;
        assign hif.regwriteW   = regwriteW;
        assign hif.ResultSrcE0 = ResultSrcE0;
        assign hif.PCSrcE      = PCSrcE;
        assign hif.RtypedivE   = RtypedivE;
        assign hif.DIV_validE  = DIV_validE;

        hazard_unit_mc #(.REG_AW(5), .DIV_LAT(LAT), .CNT_W(CW)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .hz    (hif)
        );

        assign fa_a[g]  = hif.forwardaE;
        assign fb_a[g]  = hif.forwardbE;
        assign ctl_a[g] = {hif.stallF, hif.stallD, hif.stallE, hif.flushD,
                           hif.flushE, hif.flushM, hif.div_startE, hif.div_busy};
        assign cnt_a[g] = 16'(hif.div_stall_cnt);

        // A branch or a load must never resolve in E while a divide owns E.
        always @(negedge clk)
            assert (!(rst_n && hif.div_busy && (PCSrcE || ResultSrcE0)))
                else $error("illegal branch/load in E while divider busy (cfg %0d)", g);
    end

    // ---------------- reference model ----------------
    int     lat  [4] = '{8, 4, 1, 4};
    int     cmax [4] = '{65535, 65535, 65535, 7};
    longint t = 0;
    longint t0   [4];
    int     mcnt [4];
    bit     m_start [4], m_stall [4];
    int     obs_start [4], obs_stall [4];

    function automatic bit m_busy(int k);
        return (lat[k] > 1) && (t > t0[k]) && (t <= t0[k] + lat[k] - 1);
    endfunction

    function automatic logic [1:0] fwd_exp(logic [4:0] rs);
        if (rs != 0 && rs == rdM && regwriteM) return 2'b10;
        if (rs != 0 && rs == rdW && regwriteW) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            t0[k] = -1000;
            mcnt[k] = 0;
            m_start[k] = 0;
            m_stall[k] = 0;
        end
    endtask

    task automatic check_all();
        bit lw, busy, start, stall;
        longint st0;
        logic [7:0] exp;
        if (!rst_n) model_reset();
        lw = rst_n && ResultSrcE0 && rdE != 0 && (rdE == rs1D || rdE == rs2D);
        for (int k = 0; k < 4; k++) begin
            busy  = rst_n && m_busy(k);
            start = rst_n && !busy && RtypedivE && DIV_validE;
            st0   = start ? t : t0[k];
            stall = rst_n && lat[k] > 1 && t >= st0 && t < st0 + lat[k] - 1;
            m_start[k] = start;
            m_stall[k] = stall;
            exp = {lw || stall, lw || stall, stall, rst_n && PCSrcE && !stall,
                   rst_n && (lw || PCSrcE) && !stall, stall, start, busy};
            chk($sformatf("fa[%0d]", k), 32'(fa_a[k]), 32'(fwd_exp(rs1E)));
            chk($sformatf("fb[%0d]", k), 32'(fb_a[k]), 32'(fwd_exp(rs2E)));
            chk($sformatf("ctl[%0d]", k), 32'(ctl_a[k]), 32'(exp));
            chk($sformatf("cnt[%0d]", k), 32'(cnt_a[k]), 32'(mcnt[k]));
            if (rst_n) begin
                obs_start[k] += int'(ctl_a[k][1]);
                obs_stall[k] += int'(ctl_a[k][5]);
            end
        end
    endtask

    task automatic advance();
        if (rst_n)
            for (int k = 0; k < 4; k++) begin
                if (m_start[k]) t0[k] = t;
                if (m_stall[k] && mcnt[k] < cmax[k]) mcnt[k]++;
            end
        t++;
    endtask

    // The caller sets inputs just after a posedge. Outputs are checked 1 time
    // unit later, the model then steps at the edge, and the task returns 1 time
    // unit after that edge.
    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic clear_in();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        {regwriteM, regwriteW, ResultSrcE0, PCSrcE, RtypedivE, DIV_validE} = '0;
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        clear_in();
        #1;
        check_all();
        @(posedge clk);
        advance();
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            obs_start[k] = 0;
            obs_stall[k] = 0;
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       rwM, rwW, ld, pc;
        logic [1:0] fa, fb;
        logic [5:0] ctl;   // {stallF,stallD,stallE,flushD,flushE,flushM}
    } vec_t;

    vec_t vt [11];

    initial begin
        rst_n = 1'b0;
        clear_in();
        model_reset();
        //         rs1D rs2D rs1E rs2E rdE rdM rdW rwM rwW ld pc  fa     fb     ctl
        vt[0]  = '{0,   0,   5,   0,   0,  5,  5,  1,  1,  0, 0, 2'b10, 2'b00, 6'b000000};
        vt[1]  = '{0,   0,   5,   0,   0,  5,  5,  0,  1,  0, 0, 2'b01, 2'b00, 6'b000000};
        vt[2]  = '{0,   0,   0,   0,   0,  0,  0,  1,  1,  0, 0, 2'b00, 2'b00, 6'b000000};
        vt[3]  = '{0,   0,   3,   9,   0,  3,  9,  1,  1,  0, 0, 2'b10, 2'b01, 6'b000000};
        vt[4]  = '{0,   0,   0,   4,   0,  4,  4,  1,  1,  0, 0, 2'b00, 2'b10, 6'b000000};
        vt[5]  = '{0,   7,   0,   0,   7,  0,  0,  0,  0,  1, 0, 2'b00, 2'b00, 6'b110010};
        vt[6]  = '{0,   0,   0,   0,   0,  0,  0,  0,  0,  1, 0, 2'b00, 2'b00, 6'b000000};
        vt[7]  = '{7,   0,   0,   0,   7,  0,  0,  0,  0,  1, 0, 2'b00, 2'b00, 6'b110010};
        vt[8]  = '{0,   0,   0,   0,   0,  0,  0,  0,  0,  0, 1, 2'b00, 2'b00, 6'b000110};
        vt[9]  = '{7,   0,   0,   0,   7,  0,  0,  0,  0,  0, 0, 2'b00, 2'b00, 6'b000000};
        vt[10] = '{0,   2,   0,   0,   2,  0,  0,  0,  0,  1, 1, 2'b00, 2'b00, 6'b110110};

        // Reset state: every control is 0 while rst_n is low.
        reset_all();

        for (int i = 0; i < 11; i++) begin
            rs1D = vt[i].rs1D;
            rs2D = vt[i].rs2D;
            rs1E = vt[i].rs1E;
            rs2E = vt[i].rs2E;
            rdE  = vt[i].rdE;
            rdM  = vt[i].rdM;
            rdW  = vt[i].rdW;
            regwriteM   = vt[i].rwM;
            regwriteW   = vt[i].rwW;
            ResultSrcE0 = vt[i].ld;
            PCSrcE      = vt[i].pc;
            #1;
            chk($sformatf("vec%0d_fa", i), 32'(fa_a[0]), 32'(vt[i].fa));
            chk($sformatf("vec%0d_fb", i), 32'(fb_a[0]), 32'(vt[i].fb));
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_a[0][7:2]), 32'(vt[i].ctl));
            cycle();
        end
        clear_in();

        // A divide held in E for 8 cycles. A branch on the start cycle is masked.
        reset_all();
        RtypedivE = 1'b1;
        DIV_validE = 1'b1;
        PCSrcE = 1'b1;
        #1;
        chk("pcmask_lat8", 32'(ctl_a[0][4:3]), 32'd0);
        chk("pcmask_lat4", 32'(ctl_a[1][4:3]), 32'd0);
        chk("start_stall_lat8", 32'(ctl_a[0][5]), 32'd1);
        cycle();
        PCSrcE = 1'b0;
        repeat (7) cycle();
        RtypedivE = 1'b0;
        cycle();
        chk("lat8_starts", 32'(obs_start[0]), 32'd1);
        chk("lat8_stalls", 32'(obs_stall[0]), 32'd7);
        chk("lat8_cnt", 32'(cnt_a[0]), 32'd7);
        chk("lat4_starts", 32'(obs_start[1]), 32'd2);
        chk("lat4_stalls", 32'(obs_stall[1]), 32'd6);
        chk("lat1_starts", 32'(obs_start[2]), 32'd8);
        chk("lat1_stalls", 32'(obs_stall[2]), 32'd0);

        // A bubble carrying a divide opcode must not start the divider.
        reset_all();
        RtypedivE = 1'b1;
        DIV_validE = 1'b0;
        repeat (3) cycle();
        chk("bubble_starts_lat8", 32'(obs_start[0]), 32'd0);
        chk("bubble_starts_lat1", 32'(obs_start[2]), 32'd0);
        chk("bubble_stalls_lat8", 32'(obs_stall[0]), 32'd0);

        // Asynchronous reset on the third stall cycle.
        reset_all();
        RtypedivE = 1'b1;
        DIV_validE = 1'b1;
        cycle();
        cycle();
        #1;
        check_all();
        chk("mid_stall_before_rst", 32'(ctl_a[0][5]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all();
        chk("rst_stallE", 32'(ctl_a[0][5]), 32'd0);
        chk("rst_cnt", 32'(cnt_a[0]), 32'd0);
        chk("rst_busy", 32'(ctl_a[0][0]), 32'd0);
        @(posedge clk);
        advance();
        #1;
        RtypedivE = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle", 32'(ctl_a[0][0]), 32'd0);
        cycle();

        // Three back-to-back divides on the 3-bit counter: 9 stall cycles
        // saturate the count at 7.
        reset_all();
        RtypedivE = 1'b1;
        DIV_validE = 1'b1;
        repeat (12) cycle();
        RtypedivE = 1'b0;
        chk("sat_stalls", 32'(obs_stall[3]), 32'd9);
        chk("sat_cnt", 32'(cnt_a[3]), 32'd7);
        chk("lat8_cnt_12cyc", 32'(cnt_a[0]), 32'd11);

        // Randomized traffic. Branches and loads are held off while any
        // divider is busy.
        reset_all();
        for (int i = 0; i < 400; i++) begin
            bit any_busy;
            any_busy = 0;
            for (int k = 0; k < 4; k++)
                if (m_busy(k)) any_busy = 1;
            rs1D = 5'($urandom_range(0, 3));
            rs2D = 5'($urandom_range(0, 3));
            rs1E = 5'($urandom_range(0, 3));
            rs2E = 5'($urandom_range(0, 3));
            rdE  = 5'($urandom_range(0, 3));
            rdM  = 5'($urandom_range(0, 3));
            rdW  = 5'($urandom_range(0, 3));
            regwriteM  = 1'($urandom_range(0, 1));
            regwriteW  = 1'($urandom_range(0, 1));
            DIV_validE = 1'($urandom_range(0, 1));
            RtypedivE  = ($urandom_range(0, 3) == 0);
            ResultSrcE0 = !any_busy && ($urandom_range(0, 3) == 0);
            PCSrcE      = !any_busy && ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
